// File: rtl/bram_window_fetch.sv
// bram_window_fetch
//   Feeds the sample-window selector of the gridding datapath. A flat complex
//   sample address is split into a BRAM row r and an in-row offset. Rows r and
//   r+1 are fetched and presented as one double-width word {row r+1, row r},
//   with the offset as the selector's select. The last two fetched rows are
//   kept in a small cache, so sequential or overlapping requests need one BRAM
//   read or none.
//
// Ports
//   clk, rst              single clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_addr              sample address {row, offset}
//   inv                   BRAM contents changed; drop cached rows
//   bram_en/bram_addr     BRAM read port (synchronous, one-cycle latency)
//   bram_dout             BRAM read data
//   win_valid/win_ready   window handshake
//   win_data              {row r+1, row r}; row r in the low half
//   win_select            offset of the request inside row r
module bram_window_fetch #(
  parameter int PRECISION             = 32,
  parameter int COMPLEX               = 2,
  parameter int BRAM_PARALLELISM_BITS = 4,
  parameter int BRAM_DEPTH_BITS       = 10,
  parameter int BRAM_WIDTH            = (2**BRAM_PARALLELISM_BITS)*PRECISION*COMPLEX,
  parameter int ADDR_BITS             = BRAM_DEPTH_BITS+BRAM_PARALLELISM_BITS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_BITS-1:0]             req_addr,
  input  logic                             inv,
  output logic                             bram_en,
  output logic [BRAM_DEPTH_BITS-1:0]       bram_addr,
  input  logic [BRAM_WIDTH-1:0]            bram_dout,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic [2*BRAM_WIDTH-1:0]          win_data,
  output logic [BRAM_PARALLELISM_BITS-1:0] win_select
);

  localparam logic [BRAM_DEPTH_BITS-1:0] ONE_ROW = 1;

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP_HI, OUT} state_t;

  state_t                           state;
  logic                             cache_valid;
  logic                             inv_pend;
  logic                             miss;
  logic [BRAM_DEPTH_BITS-1:0]       lo_tag;
  logic [BRAM_DEPTH_BITS-1:0]       hi_tag;
  logic [BRAM_DEPTH_BITS-1:0]       row;
  logic [BRAM_PARALLELISM_BITS-1:0] offset;
  logic [BRAM_WIDTH-1:0]            lo_row;
  logic [BRAM_WIDTH-1:0]            hi_row;

  logic [BRAM_DEPTH_BITS-1:0]       req_row;
  logic                             accept;
  logic                             full_hit;
  logic                             hi_hit;

  assign req_row = req_addr[ADDR_BITS-1:BRAM_PARALLELISM_BITS];
  // req_ready is a registered copy of (state == IDLE)
  assign accept  = req_valid && req_ready;
  // An invalidate arriving together with a request makes that request a miss
  assign full_hit = cache_valid && !inv && (req_row == lo_tag);
  assign hi_hit   = cache_valid && !inv && (req_row == hi_tag);

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cache_valid <= 1'b0;
      inv_pend    <= 1'b0;
      miss        <= 1'b0;
      lo_tag      <= '0;
      hi_tag      <= '0;
      row         <= '0;
      offset      <= '0;
      req_ready   <= 1'b1;
      bram_en     <= 1'b0;
      bram_addr   <= '0;
      win_valid   <= 1'b0;
      win_data    <= '0;
      win_select  <= '0;
    end else begin
      // Invalidates seen mid-transaction are deferred until the window retires
      if (state != IDLE && inv) inv_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (inv) cache_valid <= 1'b0;
          if (accept) begin
            row       <= req_row;
            offset    <= req_addr[BRAM_PARALLELISM_BITS-1:0];
            req_ready <= 1'b0;
            if (full_hit) begin
              win_valid  <= 1'b1;
              win_data   <= {hi_row, lo_row};
              win_select <= req_addr[BRAM_PARALLELISM_BITS-1:0];
              state      <= OUT;
            end else if (hi_hit) begin
              // Cached row r+1 becomes the new row r; only r+1 is read
              lo_tag    <= req_row;
              miss      <= 1'b0;
              bram_en   <= 1'b1;
              bram_addr <= req_row + ONE_ROW;
              state     <= RD_HI;
            end else begin
              miss      <= 1'b1;
              bram_en   <= 1'b1;
              bram_addr <= req_row;
              state     <= RD_LO;
            end
          end
        end
        RD_LO: begin
          // Row addition wraps: row 1023 pairs with row 0
          bram_addr <= row + ONE_ROW;
          state     <= RD_HI;
        end
        RD_HI: begin
          bram_en <= 1'b0;
          if (miss) lo_tag <= row;
          state   <= CAP_HI;
        end
        CAP_HI: begin
          hi_tag      <= row + ONE_ROW;
          cache_valid <= 1'b1;
          win_valid   <= 1'b1;
          win_data    <= {bram_dout, lo_row};
          win_select  <= offset;
          state       <= OUT;
        end
        OUT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            req_ready <= 1'b1;
            if (inv_pend || inv) cache_valid <= 1'b0;
            inv_pend  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          bram_en   <= 1'b0;
          win_valid <= 1'b0;
        end
      endcase
    end
  end

  // Row cache storage; its contents only matter while cache_valid is set
  always_ff @(posedge clk) begin
    if (state == IDLE && accept && hi_hit) lo_row <= hi_row;
    if (state == RD_HI && miss)            lo_row <= bram_dout;
    if (state == CAP_HI)                   hi_row <= bram_dout;
  end

endmodule

// File: tb/tb_bram_window_fetch.sv
module tb_bram_window_fetch;

  localparam int PB = 4;
  localparam int DB = 10;
  localparam int BW = 1024;
  localparam int AB = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [AB-1:0]     req_addr = '0;
  logic              inv = 1'b0;
  logic              bram_en;
  logic [DB-1:0]     bram_addr;
  logic [BW-1:0]     bram_dout = '0;
  logic              win_valid;
  logic              win_ready = 1'b1;
  logic [2*BW-1:0]   win_data;
  logic [PB-1:0]     win_select;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [2*BW-1:0] data;
    logic [PB-1:0]   sel;
  } win_t;
  win_t sb[$];

  typedef struct {
    logic [AB-1:0] addr;
    bit            inv_before;
    bit            inv_same;
    int            lat;
  } vec_t;
  vec_t tbl[11];

  bram_window_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .inv        (inv),
    .bram_en    (bram_en),
    .bram_addr  (bram_addr),
    .bram_dout  (bram_dout),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_select (win_select)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] row_val(input logic [DB-1:0] i);
    logic [BW-1:0] v;
    v = '0;
    for (int j = 0; j < 32; j++)
      v[j*32 +: 32] = {i, 6'(j), 16'(16'h5A3C ^ (i * 16'd97) ^ (j * 13))};
    return v;
  endfunction

  // Synchronous BRAM: data appears the cycle after the enable
  always @(posedge clk) if (bram_en) bram_dout <= row_val(bram_addr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_win(input string nm, input logic [2*BW-1:0] act, input logic [2*BW-1:0] exp);
    int k;
    checks++;
    if (act !== exp) begin
      fails++;
      k = 0;
      for (int j = 63; j >= 0; j--) if (act[j*32 +: 32] !== exp[j*32 +: 32]) k = j;
      $display("FAIL %s: word %0d got %08h required %08h", nm, k, act[k*32 +: 32], exp[k*32 +: 32]);
    end
  endtask

  // Scoreboard: every accepted window is compared against the queue head
  always @(negedge clk) begin
    if (win_valid && win_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_window", 64'(win_select), 64'hFFFF);
      end else begin
        win_t e;
        e = sb.pop_front();
        chk_win("win_data", win_data, e.data);
        chk("win_select", 64'(win_select), 64'(e.sel));
      end
    end
  end

  // Called #1 after a rising edge with the DUT idle
  task automatic do_req(input logic [AB-1:0] a, input bit inv_same, input int hold,
                        input int exp_lat);
    logic [DB-1:0] r;
    logic [DB-1:0] rd[$];
    logic [DB-1:0] ex[$];
    win_t          w;
    int            lat;
    r = a[AB-1:PB];
    w.data = {row_val(r + 10'd1), row_val(r)};
    w.sel  = a[PB-1:0];
    if (exp_lat == 4) begin ex.push_back(r); ex.push_back(r + 10'd1); end
    else if (exp_lat == 3) ex.push_back(r + 10'd1);
    sb.push_back(w);
    if (hold > 0) win_ready = 1'b0;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_addr  = a;
    req_valid = 1'b1;
    inv       = inv_same;
    @(posedge clk); #1;
    req_valid = 1'b0;
    inv       = 1'b0;
    lat = 1;
    while (!win_valid && lat < 10) begin
      if (bram_en) rd.push_back(bram_addr);
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency_%04h", a), 64'(lat), 64'(exp_lat));
    chk($sformatf("reads_%04h", a), 64'(rd.size()), 64'(ex.size()));
    for (int i = 0; i < ex.size() && i < rd.size(); i++)
      chk($sformatf("bram_addr_%04h_%0d", a, i), 64'(rd[i]), 64'(ex[i]));
    if (win_valid) begin
      for (int k = 0; k < hold; k++) begin
        chk_win("held_win_data", win_data, w.data);
        chk("held_win_select", 64'(win_select), 64'(w.sel));
        chk("held_req_ready", 64'(req_ready), 64'd0);
        chk("held_win_valid", 64'(win_valid), 64'd1);
        inv = (k == hold / 2);
        @(posedge clk); #1;
      end
      inv = 1'b0;
      win_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_win_valid", 64'(win_valid), 64'd0);
      chk("post_req_ready", 64'(req_ready), 64'd1);
    end else begin
      void'(sb.pop_back());
      win_ready = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{14'h0025, 0, 0, 4};
    tbl[1]  = '{14'h003A, 0, 0, 3};
    tbl[2]  = '{14'h0030, 0, 0, 1};
    tbl[3]  = '{14'h3FF0, 0, 0, 4};
    tbl[4]  = '{14'h0007, 0, 0, 3};
    tbl[5]  = '{14'h000F, 0, 0, 1};
    tbl[6]  = '{14'h0012, 0, 0, 3};
    tbl[7]  = '{14'h0012, 1, 0, 4};
    tbl[8]  = '{14'h0015, 0, 1, 4};
    tbl[9]  = '{14'h0016, 0, 0, 1};
    tbl[10] = '{14'h0200, 0, 0, 4};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_win_valid", 64'(win_valid), 64'd0);
    chk("rst_bram_en", 64'(bram_en), 64'd0);
    chk("rst_bram_addr", 64'(bram_addr), 64'd0);
    chk("rst_win_select", 64'(win_select), 64'd0);
    chk_win("rst_win_data", win_data, '0);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].inv_before) begin
        inv = 1'b1;
        @(posedge clk); #1;
        inv = 1'b0;
      end
      do_req(tbl[i].addr, tbl[i].inv_same, 0, tbl[i].lat);
    end

    // Backpressure on a full hit with an invalidate while held
    do_req(14'h0208, 0, 10, 1);
    do_req(14'h0208, 0, 0, 4);

    // Reset in the middle of a miss
    do_req(14'h00A0, 0, 0, 4);
    req_addr  = 14'h00B0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_win_valid", 64'(win_valid), 64'd0);
    chk("midrst_bram_en", 64'(bram_en), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_req_ready", 64'(req_ready), 64'd1);
    do_req(14'h00A5, 0, 0, 4);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
